irq_ctrl: RTL

Interrupt controller that sequences the single-cycle CPU's program flow for external events. It edge-detects up to N_IRQ peripheral request lines, holds them as pending, applies a CPU-written mask, and picks the highest-priority source. It then runs a request/acknowledge/return handshake with the control unit, which redirects the PC to the supplied vector at an instruction boundary. Sits beside the control unit and datapath, fed by the same I/O peripherals as in_p0/in_p1.

---
 rtl/irq_ctrl.sv | 107 ++++++++++
 1 files changed

// File: rtl/irq_ctrl.sv
// Interrupt controller: edge-detects request lines into pending bits, masks them, and runs a
// request/ack/return handshake with the control unit for the highest-priority (lowest) index.
module irq_ctrl #(
  parameter int unsigned      N_IRQ      = 4,
  parameter int unsigned      PC_W       = 10,
  parameter logic [PC_W-1:0]  VEC_BASE   = 10'h3C0,
  parameter int unsigned      VEC_STRIDE = 16,
  parameter int unsigned      ID_W       = $clog2(N_IRQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic             mask_we,
  input  logic [N_IRQ-1:0] mask_din,
  input  logic             cpu_ack,
  input  logic             cpu_reti,
  output logic             irq_req,
  output logic [PC_W-1:0]  irq_vec,
  output logic [ID_W-1:0]  irq_id,
  output logic             in_service,
  output logic [N_IRQ-1:0] pending,
  output logic [N_IRQ-1:0] mask
);

  typedef enum logic [1:0] {StIdle, StReq, StService} state_e;

  state_e           state_q;
  logic [N_IRQ-1:0] irq_prev_q;
  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] eligible;
  logic [N_IRQ-1:0] ack_clr;
  logic [ID_W-1:0]  sel_id;
  logic             sel_found;
  logic [PC_W-1:0]  sel_vec;

  assign rise     = irq_in & ~irq_prev_q;
  assign eligible = pending & mask;

  // Lowest set index wins: scan downwards so the last hit is the smallest index.
  always_comb begin
    sel_id    = '0;
    sel_found = 1'b0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        sel_id    = ID_W'(i);
        sel_found = 1'b1;
      end
    end
  end

  assign sel_vec = VEC_BASE + PC_W'(VEC_STRIDE * sel_id);

  always_comb begin
    ack_clr = '0;
    if (state_q == StReq && cpu_ack) begin
      ack_clr[irq_id] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      irq_prev_q <= '0;
      pending    <= '0;
      mask       <= '0;
      irq_req    <= 1'b0;
      irq_vec    <= '0;
      irq_id     <= '0;
      in_service <= 1'b0;
    end else begin
      irq_prev_q <= irq_in;
      // A rise coinciding with its own ack-clear is kept as a new event.
      pending    <= (pending & ~ack_clr) | rise;
      if (mask_we) begin
        mask <= mask_din;
      end
      unique case (state_q)
        StIdle: begin
          if (sel_found) begin
            irq_id  <= sel_id;
            irq_vec <= sel_vec;
            irq_req <= 1'b1;
            state_q <= StReq;
          end
        end
        StReq: begin
          if (cpu_ack) begin
            irq_req    <= 1'b0;
            in_service <= 1'b1;
            state_q    <= StService;
          end else if (!mask[irq_id]) begin
            irq_req <= 1'b0;
            state_q <= StIdle;
          end
        end
        StService: begin
          if (cpu_reti) begin
            in_service <= 1'b0;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
